// File: rtl/mac_vec_sat.sv
// N-lane signed multiply-accumulate engine; one dot-product term per lane per accepted beat.
// Latency: last beat accepted at edge T -> out_valid after edge T+2 (operand reg, product reg, accumulate).
// Backpressure: in_ready drops from the last accept until the result vector is taken on out_valid/out_ready.
module mac_vec_sat #(
    parameter int LANES     = 4,
    parameter int A_W       = 8,
    parameter int B_W       = 8,
    parameter int ACC_W     = 32,
    parameter int SAT_MODE  = 1,
    parameter int ZERO_SKIP = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_last,
    input  logic [LANES*A_W-1:0]   a,
    input  logic [LANES*B_W-1:0]   b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*ACC_W-1:0] out_acc,
    output logic [LANES-1:0]       out_sat
);

    localparam int P_W = A_W + B_W;
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    if (ACC_W < A_W + B_W + 1) begin : g_width_check
        $error("mac_vec_sat: ACC_W must be at least A_W+B_W+1");
    end

    typedef enum logic [1:0] {ACCUM, FLUSH, HOLD} state_t;

    state_t               state;
    logic                 accept;
    logic                 s0_vld, s0_last;
    logic [LANES*A_W-1:0] s0_a;
    logic [LANES*B_W-1:0] s0_b;
    logic                 s1_vld, s1_last;

    assign in_ready = (state == ACCUM);
    assign accept   = in_valid & in_ready;

    // Operands are only captured on accept so idle X inputs never reach the multipliers.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            s0_vld  <= 1'b0;
            s0_last <= 1'b0;
            s0_a    <= '0;
            s0_b    <= '0;
        end else begin
            s0_vld  <= accept;
            s0_last <= accept & in_last;
            if (accept) begin
                s0_a <= a;
                s0_b <= b;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            s1_vld  <= 1'b0;
            s1_last <= 1'b0;
        end else begin
            s1_vld  <= s0_vld;
            s1_last <= s0_last;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic signed [A_W-1:0] op_a;
        logic signed [B_W-1:0] op_b;
        logic signed [P_W-1:0] prod;
        logic                  skip;
        logic [P_W-1:0]        prod_q;
        logic                  skip_q;
        logic [ACC_W:0]        term, sum;
        logic                  ovf;
        logic [ACC_W-1:0]      acc_q, acc_nxt, res_q;
        logic                  sat_q, res_sat_q;

        assign op_a = s0_a[i*A_W +: A_W];
        assign op_b = s0_b[i*B_W +: B_W];
        assign prod = P_W'(op_a) * P_W'(op_b);
        assign skip = (ZERO_SKIP != 0) && ((op_a == '0) || (op_b == '0));

        // A skipped lane leaves its product register untouched; S2 substitutes zero.
        always_ff @(posedge clk) begin
            if (!rst_n || clr) begin
                prod_q <= '0;
                skip_q <= 1'b0;
            end else if (s0_vld) begin
                skip_q <= skip;
                if (!skip) begin
                    prod_q <= prod;
                end
            end
        end

        assign term = skip_q ? '0 : {{(ACC_W+1-P_W){prod_q[P_W-1]}}, prod_q};
        assign sum  = {acc_q[ACC_W-1], acc_q} + term;
        assign ovf  = sum[ACC_W] ^ sum[ACC_W-1];

        always_comb begin
            acc_nxt = sum[ACC_W-1:0];
            if (ovf && (SAT_MODE != 0)) begin
                acc_nxt = sum[ACC_W] ? ACC_MIN : ACC_MAX;
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n || clr) begin
                acc_q     <= '0;
                sat_q     <= 1'b0;
                res_q     <= '0;
                res_sat_q <= 1'b0;
            end else if (s1_vld) begin
                if (s1_last) begin
                    res_q     <= acc_nxt;
                    res_sat_q <= sat_q | ovf;
                    acc_q     <= '0;
                    sat_q     <= 1'b0;
                end else begin
                    acc_q     <= acc_nxt;
                    sat_q     <= sat_q | ovf;
                end
            end
        end

        assign out_acc[i*ACC_W +: ACC_W] = res_q;
        assign out_sat[i]                = res_sat_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            state     <= ACCUM;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept && in_last) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (s1_vld && s1_last) begin
                        state     <= HOLD;
                        out_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= ACCUM;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= ACCUM;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    a_operands_known: assert property (@(posedge clk) disable iff (!rst_n)
        accept |-> !$isunknown({a, b}));

endmodule
